// File: rtl/morse_pattern_sequencer.sv
// Morse pattern sequencer: latches a letter, loads its 12-bit Morse pattern into
// the downstream shift register, then issues one shift-enable per symbol period.
module morse_pattern_sequencer #(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned PATTERN_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           letter_sel,
    output logic [PATTERN_W-1:0] pattern,
    output logic                 loadn,
    output logic                 enable,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SHIFT_W = 4;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(PATTERN_W - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_MAX  = SHIFT_W'(PATTERN_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [TICK_W-1:0]      tick_q;
    logic [TICK_W-1:0]      tick_d;
    logic [SHIFT_W-1:0]     shift_q;
    logic [SHIFT_W-1:0]     shift_d;
    logic                   tick_last;

    logic [PATTERN_W-1:0]   pattern_d;
    logic                   loadn_d;
    logic                   enable_d;
    logic                   busy_d;
    logic                   done_d;

    // Morse table, LSB is sent first: dot=1, dash=111, gap=0
    function automatic logic [PATTERN_W-1:0] pattern_lut(input logic [2:0] sel);
        logic [PATTERN_W-1:0] val;
        val = '0;
        case (sel)
            3'd0: val = PATTERN_W'(12'h01D);
            3'd1: val = PATTERN_W'(12'h157);
            3'd2: val = PATTERN_W'(12'h5D7);
            3'd3: val = PATTERN_W'(12'h057);
            3'd4: val = PATTERN_W'(12'h001);
            3'd5: val = PATTERN_W'(12'h175);
            3'd6: val = PATTERN_W'(12'h177);
            3'd7: val = PATTERN_W'(12'h055);
            default: val = '0;
        endcase
        return val;
    endfunction

    assign tick_last = (tick_q == TICK_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (tick_last && (shift_q == SHIFT_LAST)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Symbol-period tick counter and saturating shift counter, next values
    always_comb begin
        tick_d  = tick_q;
        shift_d = shift_q;
        case (state_q)
            ST_LOAD: begin
                tick_d  = '0;
                shift_d = '0;
            end
            ST_SHIFT: begin
                tick_d = tick_last ? '0 : tick_q + TICK_W'(1);
                if (tick_last && (shift_q != SHIFT_MAX)) begin
                    shift_d = shift_q + SHIFT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q  <= '0;
            shift_q <= '0;
        end else begin
            tick_q  <= tick_d;
            shift_q <= shift_d;
        end
    end

    // Output decode from next state so every output lands in the cycle of its state
    always_comb begin
        pattern_d = pattern;
        if ((state_q == ST_IDLE) && start) begin
            pattern_d = pattern_lut(letter_sel);
        end
        loadn_d  = (state_d != ST_LOAD);
        enable_d = (state_d == ST_SHIFT) && (tick_d == TICK_LAST);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= '0;
            loadn   <= 1'b1;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            pattern <= pattern_d;
            loadn   <= loadn_d;
            enable  <= enable_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
